// File: rtl/pc_sequencer_if.sv
// Bundle between controlunit/register file and the PC sequencer.
// The master side is the sequencer, which drives pc/enables back into the datapath.
interface pc_sequencer_if;
  logic        halt;
  logic [1:0]  brtype;
  logic [1:0]  PCsrc;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [15:0] imm;
  logic [25:0] jta;
  logic [31:0] pc;
  logic [31:0] incr_pc;
  logic        fetch_en;
  logic        exec_en;
  logic        addr_err;
  logic [31:0] retired;

  modport master (
    input  halt, brtype, PCsrc, rs_data, rt_data, imm, jta,
    output pc, incr_pc, fetch_en, exec_en, addr_err, retired
  );

  modport slave (
    output halt, brtype, PCsrc, rs_data, rt_data, imm, jta,
    input  pc, incr_pc, fetch_en, exec_en, addr_err, retired
  );
endinterface

// File: rtl/pc_sequencer.sv
// MicroMIPS program counter and two-phase FETCH/EXEC sequencer.
// The PC and retired count commit only on the EXEC->FETCH edge.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] SYSCALL_ADDR = 32'h0000_0180
) (
  input  logic             clk,
  input  logic             rst,
  pc_sequencer_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;
  logic        addr_err_q, addr_err_d;

  logic [31:0] incr_pc;
  logic [31:0] br_offset;
  logic        operands_eq;
  logic        branch_taken;
  logic [31:0] next_pc;

  assign incr_pc     = pc_q + 32'd4;
  assign br_offset   = {{14{bus.imm[15]}}, bus.imm, 2'b00};
  assign operands_eq = (bus.rs_data == bus.rt_data);

  // brtype is only looked at for PCsrc=00 so an undriven brtype cannot reach pc
  always_comb begin
    branch_taken = 1'b0;
    if (bus.PCsrc == 2'b00) begin
      case (bus.brtype)
        2'b01:   branch_taken = operands_eq;
        2'b10:   branch_taken = ~operands_eq;
        2'b11:   branch_taken = bus.rs_data[31];
        default: branch_taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    next_pc = incr_pc;
    case (bus.PCsrc)
      2'b00:   next_pc = branch_taken ? (incr_pc + br_offset) : incr_pc;
      2'b01:   next_pc = {pc_q[31:28], bus.jta, 2'b00};
      2'b10:   next_pc = {bus.rs_data[31:2], 2'b00};
      2'b11:   next_pc = SYSCALL_ADDR;
      default: next_pc = incr_pc;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    retired_d  = retired_q;
    addr_err_d = 1'b0;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: if (!bus.halt) state_d = EXEC;
      EXEC: begin
        state_d    = FETCH;
        pc_d       = next_pc;
        retired_d  = retired_q + 32'd1;
        addr_err_d = (bus.PCsrc == 2'b10) && (bus.rs_data[1:0] != 2'b00);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      retired_q  <= 32'd0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      retired_q  <= retired_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.incr_pc  = incr_pc;
  assign bus.fetch_en = (state_q == FETCH) && !bus.halt;
  assign bus.exec_en  = (state_q == EXEC);
  assign bus.addr_err = addr_err_q;
  assign bus.retired  = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected next-PC values are queued when an
// instruction is driven in FETCH and compared after the EXEC->FETCH edge.
module tb_pc_sequencer;

  logic clk;
  logic rst;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_PC    (32'h0000_0000),
    .SYSCALL_ADDR(32'h0000_0180)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total;
  int          bad;
  logic [31:0] exp_q[$];
  logic [31:0] cur_pc;
  logic [31:0] exp_retired;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for a FETCH cycle, drives one instruction and checks its commit.
  task automatic applyStimulus(input string tag, input logic [1:0] bt, input logic [1:0] src,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic [15:0] im, input logic [25:0] jt,
                               input logic [31:0] exp_next, input logic exp_err);
    int n;
    n = 0;
    while (bus.fetch_en !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.fetch_en !== 1'b1) begin
      checkOutput({tag, "_fetch_timeout"}, 32'(bus.fetch_en), 32'd1);
      return;
    end
    bus.brtype  = bt;
    bus.PCsrc   = src;
    bus.rs_data = rs;
    bus.rt_data = rt;
    bus.imm     = im;
    bus.jta     = jt;
    exp_q.push_back(exp_next);
    @(negedge clk);
    checkOutput({tag, "_exec_en"}, 32'(bus.exec_en), 32'd1);
    checkOutput({tag, "_pc_hold"}, bus.pc, cur_pc);
    checkOutput({tag, "_err_exec"}, 32'(bus.addr_err), 32'd0);
    @(negedge clk);
    exp_retired = exp_retired + 32'd1;
    checkOutput({tag, "_pc"}, bus.pc, exp_q.pop_front());
    checkOutput({tag, "_incr"}, bus.incr_pc, exp_next + 32'd4);
    checkOutput({tag, "_addr_err"}, 32'(bus.addr_err), 32'(exp_err));
    checkOutput({tag, "_retired"}, bus.retired, exp_retired);
    checkOutput({tag, "_fetch_en"}, 32'(bus.fetch_en), 32'd1);
    cur_pc = exp_next;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    cur_pc      = 32'h0;
    exp_retired = 32'h0;
    rst         = 1'b1;
    bus.halt    = 1'b0;
    bus.brtype  = 2'b00;
    bus.PCsrc   = 2'b00;
    bus.rs_data = 32'h0;
    bus.rt_data = 32'h0;
    bus.imm     = 16'h0;
    bus.jta     = 26'h0;

    #1;
    checkOutput("rst_pc", bus.pc, 32'h0);
    checkOutput("rst_retired", bus.retired, 32'h0);
    checkOutput("rst_fetch_en", 32'(bus.fetch_en), 32'd0);
    checkOutput("rst_exec_en", 32'(bus.exec_en), 32'd0);
    checkOutput("rst_addr_err", 32'(bus.addr_err), 32'd0);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("idle_fetch_en", 32'(bus.fetch_en), 32'd0);
    @(negedge clk);
    checkOutput("first_fetch_en", 32'(bus.fetch_en), 32'd1);
    checkOutput("first_pc", bus.pc, 32'h0);

    applyStimulus("seq0", 2'b00, 2'b00, 32'h0, 32'h0, 16'h0, 26'h0, 32'h4, 1'b0);
    applyStimulus("seq1", 2'b00, 2'b00, 32'h0, 32'h0, 16'h0, 26'h0, 32'h8, 1'b0);
    applyStimulus("seq2", 2'b00, 2'b00, 32'h0, 32'h0, 16'h0, 26'h0, 32'hC, 1'b0);
    checkOutput("retired_three", bus.retired, 32'd3);

    applyStimulus("j100", 2'b00, 2'b01, 32'h0, 32'h0, 16'h0, 26'h40, 32'h100, 1'b0);
    applyStimulus("beq_taken", 2'b01, 2'b00, 32'd5, 32'd5, 16'hFFFF, 26'h0, 32'h100, 1'b0);
    applyStimulus("beq_not", 2'b01, 2'b00, 32'd5, 32'd6, 16'hFFFF, 26'h0, 32'h104, 1'b0);

    applyStimulus("j200a", 2'b00, 2'b01, 32'h0, 32'h0, 16'h0, 26'h80, 32'h200, 1'b0);
    applyStimulus("bltz", 2'b11, 2'b00, 32'h8000_0000, 32'h0, 16'h0010, 26'h0, 32'h244, 1'b0);
    applyStimulus("j200b", 2'b00, 2'b01, 32'h0, 32'h0, 16'h0, 26'h80, 32'h200, 1'b0);
    applyStimulus("bne_eq", 2'b10, 2'b00, 32'd7, 32'd7, 16'h0010, 26'h0, 32'h204, 1'b0);

    applyStimulus("jr_hi", 2'b00, 2'b10, 32'h1000_0000, 32'h0, 16'h0, 26'h0, 32'h1000_0000, 1'b0);
    applyStimulus("j_region", 2'b11, 2'b01, 32'h8000_0000, 32'h0, 16'h0, 26'h0000100, 32'h1000_0400, 1'b0);
    applyStimulus("syscall", 2'bxx, 2'b11, 32'h0, 32'h0, 16'h0, 26'h0, 32'h180, 1'b0);

    applyStimulus("jr_misal", 2'b00, 2'b10, 32'h0000_2003, 32'h0, 16'h0, 26'h0, 32'h2000, 1'b1);
    applyStimulus("jr_align", 2'b00, 2'b10, 32'h0000_2000, 32'h0, 16'h0, 26'h0, 32'h2000, 1'b0);

    bus.halt = 1'b1;
    #1;
    checkOutput("halt_fetch_en0", 32'(bus.fetch_en), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("halt_fetch_en_%0d", i), 32'(bus.fetch_en), 32'd0);
      checkOutput($sformatf("halt_exec_en_%0d", i), 32'(bus.exec_en), 32'd0);
      checkOutput($sformatf("halt_pc_%0d", i), bus.pc, cur_pc);
      checkOutput($sformatf("halt_retired_%0d", i), bus.retired, exp_retired);
    end
    bus.halt = 1'b0;
    #1;
    checkOutput("unhalt_fetch_en", 32'(bus.fetch_en), 32'd1);
    applyStimulus("after_halt", 2'b00, 2'b00, 32'h0, 32'h0, 16'h0, 26'h0, 32'h2004, 1'b0);

    bus.PCsrc = 2'b01;
    bus.jta   = 26'h3FF;
    @(negedge clk);
    checkOutput("abort_exec_en", 32'(bus.exec_en), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort_pc", bus.pc, 32'h0);
    checkOutput("abort_retired", bus.retired, 32'h0);
    checkOutput("abort_exec_en0", 32'(bus.exec_en), 32'd0);
    @(negedge clk);
    checkOutput("abort_pc_held", bus.pc, 32'h0);
    rst         = 1'b0;
    cur_pc      = 32'h0;
    exp_retired = 32'h0;
    applyStimulus("post_rst", 2'b00, 2'b00, 32'h0, 32'h0, 16'h0, 26'h0, 32'h4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
